// File: rtl/ed2_pen_status_in_pio.sv
// rtl/ed2_pen_status_in_pio.sv - Avalon-MM input PIO with edge capture and masked level interrupt
module ed2_pen_status_in_pio #(
    parameter int unsigned  WIDTH      = 16,
    parameter int unsigned  EDGE_TYPE  = 0,
    parameter logic [31:0]  RESET_MASK = 32'h0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_MASK     = 2'd2;
    localparam logic [1:0] ADDR_CAPTURE  = 2'd3;
    localparam logic [1:0] PRIME_DONE    = 2'd3;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] irq_mask;
    logic [1:0]       prime_cnt;

    logic             wr_en;
    logic             primed;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] detect;
    logic [WIDTH-1:0] clr;
    logic [31:0]      rd_mux;

    // Bits above WIDTH are architecturally ignored on writes.
    logic             unused_wdata;
    assign unused_wdata = ^writedata;

    assign wr_en  = chipselect & ~write_n;
    assign primed = (prime_cnt == PRIME_DONE);

    // Detection stays off until sync2 and prev both hold real post-reset samples.
    always_comb begin
        rise   = sync2 & ~prev;
        fall   = ~sync2 & prev;
        detect = '0;
        if (primed) begin
            if (EDGE_TYPE == 0) begin
                detect = rise;
            end else if (EDGE_TYPE == 1) begin
                detect = fall;
            end else begin
                detect = rise | fall;
            end
        end
    end

    always_comb begin
        clr = '0;
        if (wr_en && (address == ADDR_CAPTURE)) begin
            clr = writedata[WIDTH-1:0];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:    rd_mux[WIDTH-1:0] = sync2;
            ADDR_MASK:    rd_mux[WIDTH-1:0] = irq_mask;
            ADDR_CAPTURE: rd_mux[WIDTH-1:0] = edge_capture;
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prime_cnt <= '0;
        end else if (!primed) begin
            prime_cnt <= prime_cnt + 2'd1;
        end
    end

    // A new edge wins over a simultaneous clear of the same bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_capture <= '0;
        end else begin
            edge_capture <= (edge_capture & ~clr) | detect;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= RESET_MASK[WIDTH-1:0];
        end else if (wr_en && (address == ADDR_MASK)) begin
            irq_mask <= writedata[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_ed2_pen_status_in_pio.sv
// tb/tb_ed2_pen_status_in_pio.sv - scoreboard bench for ed2_pen_status_in_pio, one DUT per EDGE_TYPE
module tb_ed2_pen_status_in_pio;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [W-1:0]  in_port;
    logic [31:0]   rdata [3];
    logic [2:0]    irq_v;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ed2_pen_status_in_pio #(
            .WIDTH      (W),
            .EDGE_TYPE  (g),
            .RESET_MASK (32'h0)
        ) u_dut (
            .clk        (clk),
            .reset_n    (reset_n),
            .address    (address),
            .chipselect (chipselect),
            .write_n    (write_n),
            .writedata  (writedata),
            .in_port    (in_port),
            .readdata   (rdata[g]),
            .irq        (irq_v[g])
        );
    end

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] exp;
    } rsp_t;

    int            n_cmp = 0;
    int            n_err = 0;
    rsp_t          exp_q [3][$];
    logic [W-1:0]  hist [$];
    logic [W-1:0]  m_cap [3];
    logic [W-1:0]  m_mask;
    logic          rd_req;
    bit            rsp_due;
    logic [W-1:0]  m_lvl, m_rise, m_fall, m_clr, m_det;
    logic [31:0]   m_rd;
    rsp_t          r;
    logic [1:0]    r_a;
    logic          r_cs, r_wn, r_rd;
    logic [31:0]   r_wd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        hist.delete();
        for (int t = 0; t < 3; t++) m_cap[t] = '0;
        m_mask  = '0;
        rsp_due = 0;
    endtask

    // Reference: sync2 is the input sampled two edges ago; an edge is the difference
    // between the two most recent real samples that have reached sync2 and prev.
    initial forever begin
        @(posedge clk);
        if (reset_n) begin
            m_lvl  = (hist.size() >= 2) ? hist[1] : '0;
            m_rise = '0;
            m_fall = '0;
            if (hist.size() >= 3) begin
                m_rise = hist[1] & ~hist[2];
                m_fall = ~hist[1] & hist[2];
            end
            if (rd_req) begin
                for (int t = 0; t < 3; t++) begin
                    case (address)
                        2'd0:    m_rd = {16'h0, m_lvl};
                        2'd2:    m_rd = {16'h0, m_mask};
                        2'd3:    m_rd = {16'h0, m_cap[t]};
                        default: m_rd = 32'h0;
                    endcase
                    exp_q[t].push_back('{address, m_rd});
                end
                rsp_due = 1;
            end
            m_clr = '0;
            if (chipselect && !write_n) begin
                if (address == 2'd2) m_mask = writedata[W-1:0];
                if (address == 2'd3) m_clr  = writedata[W-1:0];
            end
            for (int t = 0; t < 3; t++) begin
                m_det    = (t == 0) ? m_rise : (t == 1) ? m_fall : (m_rise | m_fall);
                m_cap[t] = (m_cap[t] & ~m_clr) | m_det;
            end
            hist.push_front(in_port);
            if (hist.size() > 4) void'(hist.pop_back());
        end
    end

    // Monitor: outputs are stable at the falling edge; inputs change one unit later.
    initial forever begin
        @(negedge clk);
        for (int t = 0; t < 3; t++)
            check($sformatf("irq_e%0d", t), {31'h0, irq_v[t]}, {31'h0, |(m_cap[t] & m_mask)});
        if (rsp_due) begin
            rsp_due = 0;
            for (int t = 0; t < 3; t++) begin
                if (exp_q[t].size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rd_e%0d no expected entry, actual=%h", t, rdata[t]);
                end else begin
                    r = exp_q[t].pop_front();
                    check($sformatf("rd_e%0d_a%0d", t, r.addr), rdata[t], r.exp);
                end
            end
        end
    end

    task automatic step(input logic [1:0] a, input logic cs, input logic wn,
                        input logic [31:0] wd, input logic rd);
        address    = a;
        chipselect = cs;
        write_n    = wn;
        writedata  = wd;
        rd_req     = rd;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        step(2'd1, 1'b0, 1'b1, 32'h0, 1'b0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        step(a, 1'b1, 1'b0, d, 1'b0);
    endtask

    task automatic rd(input logic [1:0] a);
        step(a, 1'b1, 1'b1, 32'h0, 1'b1);
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        rd_req     = 1'b0;
        in_port    = 16'hFFFF;
        model_clear();
        @(negedge clk);
        #1;
        for (int t = 0; t < 3; t++) begin
            check("rst_readdata", rdata[t], 32'h0);
            check("rst_irq", {31'h0, irq_v[t]}, 32'h0);
        end
        @(negedge clk);
        #1;
        reset_n = 1'b1;

        // Lines high through reset: level visible, nothing captured.
        repeat (10) idle();
        rd(2'd0);
        check("t1_data", rdata[0], 32'h0000FFFF);
        rd(2'd3);
        check("t1_capture", rdata[0], 32'h0);
        check("t1_irq", {31'h0, irq_v[0]}, 32'h0);

        // Rising edge on bit0 with mask bit0 set: capture two edges later.
        in_port = 16'h0000;
        repeat (4) idle();
        wr(2'd3, 32'hFFFF);
        wr(2'd2, 32'h0001);
        in_port[0] = 1'b1;
        idle();
        check("t2_irq_k", {31'h0, irq_v[0]}, 32'h0);
        idle();
        check("t2_irq_k1", {31'h0, irq_v[0]}, 32'h0);
        idle();
        check("t2_irq_k2", {31'h0, irq_v[0]}, 32'h1);
        rd(2'd3);
        check("t2_capture", rdata[0], 32'h1);

        // Clear, then clear colliding with a new edge.
        wr(2'd3, 32'h1);
        check("t3_irq_cleared", {31'h0, irq_v[0]}, 32'h0);
        in_port[0] = 1'b0;
        repeat (3) idle();
        in_port[0] = 1'b1;
        idle();
        idle();
        check("t3_irq_pre", {31'h0, irq_v[0]}, 32'h0);
        wr(2'd3, 32'h1);
        check("t3_set_wins_irq", {31'h0, irq_v[0]}, 32'h1);
        rd(2'd3);
        check("t3_set_wins_cap", {31'h0, rdata[0][0]}, 32'h1);

        // Any-edge capture with interrupts masked, then unmask.
        repeat (3) idle();
        wr(2'd3, 32'hFFFF);
        wr(2'd2, 32'h0);
        in_port[5] = 1'b1;
        repeat (3) idle();
        in_port[5] = 1'b0;
        repeat (3) idle();
        rd(2'd3);
        check("t4_capture_any", rdata[2], 32'h20);
        check("t4_irq_masked", {31'h0, irq_v[2]}, 32'h0);
        wr(2'd2, 32'h20);
        check("t4_irq_unmask", {31'h0, irq_v[2]}, 32'h1);

        // Read-only and reserved addresses ignore writes; mask truncates to WIDTH.
        wr(2'd0, 32'hDEADBEEF);
        wr(2'd1, 32'hDEADBEEF);
        rd(2'd0);
        check("t5_data", rdata[0], {16'h0, in_port});
        rd(2'd1);
        check("t5_reserved", rdata[1], 32'h0);
        wr(2'd2, 32'hFFFF1234);
        rd(2'd2);
        check("t5_mask_trunc", rdata[2], 32'h00001234);

        // Asynchronous reset mid-operation, then priming after release.
        wr(2'd3, 32'hFFFF);
        wr(2'd2, 32'h00FF);
        in_port = 16'h0000;
        repeat (4) idle();
        in_port = 16'h00FF;
        repeat (4) idle();
        rd(2'd3);
        check("t6_capture_pre", rdata[0], 32'h00FF);
        check("t6_irq_pre", {31'h0, irq_v[0]}, 32'h1);
        reset_n = 1'b0;
        model_clear();
        #1;
        for (int t = 0; t < 3; t++) begin
            check("t6_rst_irq", {31'h0, irq_v[t]}, 32'h0);
            check("t6_rst_readdata", rdata[t], 32'h0);
        end
        @(negedge clk);
        #1;
        in_port = 16'hFFFF;
        reset_n = 1'b1;
        repeat (6) idle();
        rd(2'd3);
        for (int t = 0; t < 3; t++) check("t6_no_prime_capture", rdata[t], 32'h0);

        // Randomised traffic against the reference model.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 2) == 0) in_port = in_port ^ (W'($urandom) & W'($urandom));
            r_a  = 2'($urandom_range(0, 3));
            r_cs = 1'($urandom_range(0, 1));
            r_wn = ($urandom_range(0, 2) != 0);
            r_wd = $urandom;
            if (r_a == 2'd3) r_wd = r_wd & $urandom;
            r_rd = 1'($urandom_range(0, 1));
            step(r_a, r_cs, r_wn, r_wd, r_rd);
            if (i == 750) begin
                reset_n = 1'b0;
                model_clear();
                @(negedge clk);
                #1;
                reset_n = 1'b1;
            end
        end
        idle();
        for (int t = 0; t < 3; t++) check("q_drain", exp_q[t].size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
